// File: rtl/light_channel_arbiter_if.sv
// rtl/light_channel_arbiter_if.sv - ESP remote command valid/ready handshake bundle
// Ports (signals):
//   esp_valid  ESP command valid              (master -> slave)
//   esp_ch     target LED channel, CH_W bits  (master -> slave)
//   esp_on     requested LED state            (master -> slave)
//   esp_ready  controller accepts this cycle  (slave -> master)
interface light_channel_arbiter_if #(
    parameter int CH_W = 2
);
    logic            esp_valid;
    logic [CH_W-1:0] esp_ch;
    logic            esp_on;
    logic            esp_ready;

    modport master (
        output esp_valid,
        output esp_ch,
        output esp_on,
        input  esp_ready
    );

    modport slave (
        input  esp_valid,
        input  esp_ch,
        input  esp_on,
        output esp_ready
    );
endinterface

// File: rtl/light_channel_arbiter.sv
// rtl/light_channel_arbiter.sv - per-channel LED arbiter: ESP remote vs debounced pushbutton with auto-off
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   clr_i      synchronous clear, all channels off, blocks ESP acceptance
//   sw_mode_i  per-channel source: 1 = local pushbutton, 0 = ESP remote
//   pb_i       raw asynchronous pushbuttons, active-high
//   esp        ESP command handshake (slave side)
//   err_o      1-cycle pulse: accepted command was rejected
//   led_o      registered LED drive
//   event_o    1-cycle pulse on each LED change
module light_channel_arbiter #(
    parameter int N_CH       = 4,
    parameter int CH_W       = 2,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic [N_CH-1:0]             sw_mode_i,
    input  logic [N_CH-1:0]             pb_i,
    light_channel_arbiter_if.slave      esp,
    output logic                        err_o,
    output logic [N_CH-1:0]             led_o,
    output logic [N_CH-1:0]             event_o
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [N_CH-1:0] pb_meta_q, pb_sync_q;
    logic [N_CH-1:0] deb_q, deb_d;
    logic [DW-1:0]   deb_cnt_q [N_CH];
    logic [DW-1:0]   deb_cnt_d [N_CH];
    logic [TW-1:0]   tmr_q [N_CH];
    logic [TW-1:0]   tmr_d [N_CH];
    logic [N_CH-1:0] led_q, led_d;
    logic [N_CH-1:0] event_q;
    logic            err_q, err_d;
    logic            ready_q, ready_d;

    logic [N_CH-1:0] press;
    logic [N_CH-1:0] hit_ch;
    logic [N_CH-1:0] cmd_hit;
    logic [31:0]     ch_ext;
    logic            accept;
    logic            reject;

    // READY is masked by clr_i so a command offered during a clear is never taken.
    assign esp.esp_ready = ready_q & ~clr_i;
    assign accept        = esp.esp_valid & esp.esp_ready;
    assign ch_ext        = {{(32 - CH_W){1'b0}}, esp.esp_ch};

    // Debouncer: the level flips only after DEB_CYCLES consecutive synced samples
    // that disagree with it; the press pulse fires on the same cycle as a 0->1 flip.
    always_comb begin
        deb_d = deb_q;
        press = '0;
        for (int i = 0; i < N_CH; i++) begin
            deb_cnt_d[i] = '0;
            if (pb_sync_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = pb_sync_q[i];
                    press[i] = pb_sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Command decode: an out-of-range index matches no channel, which is the reject path.
    always_comb begin
        hit_ch = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit_ch[i] = (ch_ext == 32'(i));
        end
        reject  = accept & (~(|hit_ch) | (|(hit_ch & sw_mode_i)));
        cmd_hit = accept ? (hit_ch & ~sw_mode_i) : '0;
        err_d   = reject;
        ready_d = ~accept;
    end

    // Per-channel next state: clear > command/press > timeout expiry.
    always_comb begin
        led_d = led_q;
        for (int i = 0; i < N_CH; i++) begin
            tmr_d[i] = '0;
            if (clr_i) begin
                led_d[i] = 1'b0;
            end else if (cmd_hit[i]) begin
                led_d[i] = esp.esp_on;
            end else if (press[i] && sw_mode_i[i]) begin
                led_d[i] = ~led_q[i];
            end else if ((TIMEOUT > 0) && led_q[i]) begin
                if (tmr_q[i] == TMR_LAST) begin
                    led_d[i] = 1'b0;
                end else begin
                    tmr_d[i] = tmr_q[i] + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pb_meta_q <= '0;
            pb_sync_q <= '0;
            deb_q     <= '0;
            led_q     <= '0;
            event_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                deb_cnt_q[i] <= '0;
                tmr_q[i]     <= '0;
            end
        end else begin
            pb_meta_q <= pb_i;
            pb_sync_q <= pb_meta_q;
            deb_q     <= deb_d;
            led_q     <= led_d;
            event_q   <= led_d ^ led_q;
            err_q     <= err_d;
            ready_q   <= ready_d;
            for (int i = 0; i < N_CH; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                tmr_q[i]     <= tmr_d[i];
            end
        end
    end

    assign led_o   = led_q;
    assign event_o = event_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_light_channel_arbiter.sv
// tb/tb_light_channel_arbiter.sv - self-checking bench for light_channel_arbiter
module tb_light_channel_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] sw_mode = 4'b0000;
    logic [3:0] pb = 4'b0000;
    logic       err;
    logic [3:0] led;
    logic [3:0] event_p;

    logic       err3;
    logic [3:0] led3;
    logic [3:0] event3;

    int n_pass = 0;
    int n_total = 0;
    int ev_cnt [4];

    always #5 clk = ~clk;

    light_channel_arbiter_if #(.CH_W(2)) esp_if ();
    light_channel_arbiter_if #(.CH_W(3)) esp_if3 ();

    light_channel_arbiter #(.N_CH(4), .CH_W(2), .DEB_CYCLES(4), .TIMEOUT(20)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (clr),
        .sw_mode_i (sw_mode),
        .pb_i      (pb),
        .esp       (esp_if),
        .err_o     (err),
        .led_o     (led),
        .event_o   (event_p)
    );

    light_channel_arbiter #(.N_CH(4), .CH_W(3), .DEB_CYCLES(4), .TIMEOUT(20)) dut3 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (1'b0),
        .sw_mode_i (4'b0000),
        .pb_i      (4'b0000),
        .esp       (esp_if3),
        .err_o     (err3),
        .led_o     (led3),
        .event_o   (event3)
    );

    typedef struct {
        logic       clr;
        logic [3:0] sw;
        logic       valid;
        logic [1:0] ch;
        logic       on;
        logic [3:0] led;
        logic [3:0] ev;
        logic       err;
        logic       rdy;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (event_p[c]) ev_cnt[c]++;
        end
    endtask

    task automatic esp_cmd(input logic [1:0] ch, input logic on);
        esp_if.esp_valid = 1'b1;
        esp_if.esp_ch    = ch;
        esp_if.esp_on    = on;
        @(negedge clk);
        esp_if.esp_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        esp_if.esp_valid  = 1'b0;
        esp_if.esp_ch     = 2'd0;
        esp_if.esp_on     = 1'b0;
        esp_if3.esp_valid = 1'b0;
        esp_if3.esp_ch    = 3'd0;
        esp_if3.esp_on    = 1'b0;
        for (int c = 0; c < 4; c++) ev_cnt[c] = 0;

        //                clr   sw       vld   ch     on    led      ev       err   rdy
        vecs[0]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0101, 4'b0001, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'b1000, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0100, 4'b0001, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'b1000, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};

        // Reset state and READY rising one edge after release
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_event", 32'(event_p), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_ready", 32'(esp_if.esp_ready), 32'h0);
        rst_n = 1'b1;
        #1 chk("rel_ready_pre_edge", 32'(esp_if.esp_ready), 32'h0);
        @(negedge clk);
        chk("rel_ready", 32'(esp_if.esp_ready), 32'h1);
        chk("rel_led", 32'(led), 32'h0);
        chk("rel_event", 32'(event_p), 32'h0);

        // ESP handshake vectors
        for (int v = 0; v < 18; v++) begin
            clr              = vecs[v].clr;
            sw_mode          = vecs[v].sw;
            esp_if.esp_valid = vecs[v].valid;
            esp_if.esp_ch    = vecs[v].ch;
            esp_if.esp_on    = vecs[v].on;
            @(negedge clk);
            chk($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].led));
            chk($sformatf("vec%0d_event", v), 32'(event_p), 32'(vecs[v].ev));
            chk($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].err));
            chk($sformatf("vec%0d_ready", v), 32'(esp_if.esp_ready), 32'(vecs[v].rdy));
        end
        clr = 1'b0;
        esp_if.esp_valid = 1'b0;

        // Widened channel index: ch 5 does not exist
        esp_if3.esp_valid = 1'b1;
        esp_if3.esp_ch    = 3'd5;
        esp_if3.esp_on    = 1'b1;
        @(negedge clk);
        esp_if3.esp_valid = 1'b0;
        chk("w3_err", 32'(err3), 32'h1);
        chk("w3_led", 32'(led3), 32'h0);
        chk("w3_ready_drop", 32'(esp_if3.esp_ready), 32'h0);
        @(negedge clk);
        chk("w3_err_clear", 32'(err3), 32'h0);
        esp_if3.esp_valid = 1'b1;
        esp_if3.esp_ch    = 3'd3;
        @(negedge clk);
        esp_if3.esp_valid = 1'b0;
        chk("w3_ch3_led", 32'(led3), 32'h8);
        chk("w3_ch3_err", 32'(err3), 32'h0);

        // Local pushbutton: 10 high, 10 low, 10 high
        sw_mode = 4'b1111;
        for (int c = 0; c < 4; c++) ev_cnt[c] = 0;
        pb = 4'b0001;
        run(10);
        chk("pb_on", 32'(led), 32'h1);
        pb = 4'b0000;
        run(10);
        chk("pb_release_hold", 32'(led), 32'h1);
        pb = 4'b0001;
        run(10);
        chk("pb_off", 32'(led), 32'h0);
        pb = 4'b0000;
        run(10);
        chk("pb_events_ch0", 32'(ev_cnt[0]), 32'd2);
        pb = 4'b0010;
        run(2);
        pb = 4'b0000;
        run(10);
        chk("glitch_led", 32'(led), 32'h0);
        chk("glitch_events", 32'(ev_cnt[1]), 32'd0);

        // Remote mode ignores presses; switching mode while held changes nothing
        sw_mode = 4'b0000;
        pb = 4'b0100;
        run(10);
        chk("remote_press_ignored", 32'(led), 32'h0);
        sw_mode = 4'b0100;
        run(5);
        chk("mode_switch_no_change", 32'(led), 32'h0);
        chk("mode_switch_events", 32'(ev_cnt[2]), 32'd0);
        pb = 4'b0000;
        run(10);
        sw_mode = 4'b0000;

        // Auto-off after exactly 20 cycles
        esp_if.esp_valid = 1'b1;
        esp_if.esp_ch    = 2'd1;
        esp_if.esp_on    = 1'b1;
        @(negedge clk);
        esp_if.esp_valid = 1'b0;
        chk("to_on", 32'(led), 32'h2);
        repeat (19) @(negedge clk);
        chk("to_still_on_19", 32'(led[1]), 32'h1);
        @(negedge clk);
        chk("to_off_20", 32'(led[1]), 32'h0);
        chk("to_event_20", 32'(event_p[1]), 32'h1);

        // Re-sent command at cycle 15 restarts the timer: off at cycle 35
        esp_if.esp_valid = 1'b1;
        @(negedge clk);
        esp_if.esp_valid = 1'b0;
        chk("to2_on", 32'(led[1]), 32'h1);
        repeat (14) @(negedge clk);
        esp_if.esp_valid = 1'b1;
        @(negedge clk);
        esp_if.esp_valid = 1'b0;
        chk("to2_resend_no_event", 32'(event_p[1]), 32'h0);
        repeat (19) @(negedge clk);
        chk("to2_still_on_34", 32'(led[1]), 32'h1);
        @(negedge clk);
        chk("to2_off_35", 32'(led[1]), 32'h0);
        chk("to2_event_35", 32'(event_p[1]), 32'h1);

        // CLR with all lit and VALID high
        for (int c = 0; c < 4; c++) esp_cmd(2'(c), 1'b1);
        chk("clr_pre_all_on", 32'(led), 32'hF);
        clr = 1'b1;
        esp_if.esp_valid = 1'b1;
        esp_if.esp_ch    = 2'd2;
        esp_if.esp_on    = 1'b1;
        #1 chk("clr_ready_low", 32'(esp_if.esp_ready), 32'h0);
        @(negedge clk);
        chk("clr_led", 32'(led), 32'h0);
        chk("clr_event", 32'(event_p), 32'hF);
        clr = 1'b0;
        esp_if.esp_valid = 1'b0;
        #1 chk("clr_cmd_not_taken", 32'(esp_if.esp_ready), 32'h1);
        @(negedge clk);

        // Reset asserted mid-command
        esp_cmd(2'd0, 1'b1);
        esp_if.esp_valid = 1'b1;
        esp_if.esp_ch    = 2'd1;
        esp_if.esp_on    = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_led", 32'(led), 32'h0);
        chk("mid_rst_event", 32'(event_p), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_ready", 32'(esp_if.esp_ready), 32'h0);
        esp_if.esp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(esp_if.esp_ready), 32'h1);
        chk("post_rst_led", 32'(led), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
